mano_mem_arbiter: RTL and testbench



---
 rtl/mano_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mano_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mano_mem_arbiter.sv
// rtl/mano_mem_arbiter.sv - CPU/DMA arbiter for the single-port 32x16 Mano main memory
// Optional feature macro: MANO_ARB_RR_EN (strict alternation instead of CPU priority + starvation bound)
module mano_mem_arbiter #(
  parameter int AW         = 5,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;          // 1 = DMA owns the current access
  logic          we_q, we_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          grant_dma;

`ifdef MANO_ARB_RR_EN
  logic          last_dma_q, last_dma_d;    // 0 = last grant went to the CPU
`else
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;
`endif

  // Next-state, arbitration and registered memory-side outputs
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    grant_dma   = 1'b0;
`ifdef MANO_ARB_RR_EN
    last_dma_d  = last_dma_q;
`else
    starve_d    = starve_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef MANO_ARB_RR_EN
        grant_dma = dma_req && (!cpu_req || !last_dma_q);
        if (cpu_req || dma_req) last_dma_d = grant_dma;
`else
        grant_dma = dma_req && (!cpu_req || (starve_q == SW'(STARVE_MAX)));
        // dma_req=1 without a DMA grant means the CPU won while DMA waited
        if (!dma_req || grant_dma)            starve_d = '0;
        else if (starve_q != SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
`endif
        if (cpu_req || dma_req) begin
          owner_d     = grant_dma;
          we_d        = grant_dma ? dma_we    : cpu_we;
          mem_addr_d  = grant_dma ? dma_addr  : cpu_addr;
          mem_wdata_d = grant_dma ? dma_wdata : cpu_wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_dma ? dma_we    : cpu_we;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cpu_ack_d = !owner_q;
        dma_ack_d = owner_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (!we_q) begin
          if (owner_q) dma_rdata_d = mem_rdata;
          else         cpu_rdata_d = mem_rdata;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
`ifdef MANO_ARB_RR_EN
      last_dma_q  <= 1'b0;
`else
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
`ifdef MANO_ARB_RR_EN
      last_dma_q  <= last_dma_d;
`else
      starve_q    <= starve_d;
`endif
    end
  end

  // Read data arrives from memory during the ack cycle, so pass it through then
  always_comb begin
    cpu_rdata = (cpu_ack_q && !we_q) ? mem_rdata : cpu_rdata_q;
    dma_rdata = (dma_ack_q && !we_q) ? mem_rdata : dma_rdata_q;
  end

  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mano_mem_arbiter.sv
// tb/tb_mano_mem_arbiter.sv - self-checking bench for mano_mem_arbiter
module tb_mano_mem_arbiter;
  localparam int AW   = 5;
  localparam int DW   = 16;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;
  logic          cpu_ack, dma_ack, mem_en, mem_we, busy;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;

  mano_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 10) return 16'h0005;
    return 16'(i * 16'h1111 + 7);
  endfunction

  // Synchronous-read memory array
  logic [DW-1:0] tb_mem [32];
  logic          mem_load = 1'b0;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) tb_mem[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  // Transaction-level reference model
  logic [DW-1:0] gmem [32];
  int            cyc, idle_cyc, ack_cyc, ack_port;
  logic          exp_we, exp_read;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd, exp_rd, last_cpu_rd, last_dma_rd;
  int            grant_log[$];
  int            p_cpu = 0, p_dma = 0;
`ifdef MANO_ARB_RR_EN
  int            last_grant;
`else
  int            starve;
`endif

  task automatic model_reset();
    cyc = 0; idle_cyc = 0; ack_cyc = -10; ack_port = 0;
    last_cpu_rd = '0; last_dma_rd = '0; exp_read = 1'b0;
    grant_log.delete();
    for (int i = 0; i < 32; i++) gmem[i] = init_val(i);
`ifdef MANO_ARB_RR_EN
    last_grant = 1;
`else
    starve = 0;
`endif
  endtask

  task automatic set_cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  // Called at a falling edge: check outputs, update requesters, arbitrate, advance one cycle
  task automatic step();
    logic ec, ed;
    logic [DW-1:0] e;
    int win;
    ec = (cyc == ack_cyc) && (ack_port == 1);
    ed = (cyc == ack_cyc) && (ack_port == 2);
    checks++;
    if (cpu_ack !== ec) begin errors++; $display("FAIL cpu_ack cyc=%0d got %b expected %b", cyc, cpu_ack, ec); end
    checks++;
    if (dma_ack !== ed) begin errors++; $display("FAIL dma_ack cyc=%0d got %b expected %b", cyc, dma_ack, ed); end
    e = (ec && exp_read) ? exp_rd : last_cpu_rd;
    checks++;
    if (cpu_rdata !== e) begin errors++; $display("FAIL cpu_rdata cyc=%0d got %h expected %h", cyc, cpu_rdata, e); end
    e = (ed && exp_read) ? exp_rd : last_dma_rd;
    checks++;
    if (dma_rdata !== e) begin errors++; $display("FAIL dma_rdata cyc=%0d got %h expected %h", cyc, dma_rdata, e); end
    checks++;
    if (busy !== (cyc != idle_cyc)) begin errors++; $display("FAIL busy cyc=%0d got %b expected %b", cyc, busy, cyc != idle_cyc); end
    checks++;
    if (mem_en !== (cyc == ack_cyc - 1)) begin errors++; $display("FAIL mem_en cyc=%0d got %b expected %b", cyc, mem_en, cyc == ack_cyc - 1); end
    if (cyc == ack_cyc - 1) begin
      checks++;
      if (mem_we !== exp_we || mem_addr !== exp_addr) begin
        errors++; $display("FAIL mem_cmd cyc=%0d got we=%b addr=%0d expected we=%b addr=%0d", cyc, mem_we, mem_addr, exp_we, exp_addr);
      end
      if (exp_we) begin
        checks++;
        if (mem_wdata !== exp_wd) begin errors++; $display("FAIL mem_wdata cyc=%0d got %h expected %h", cyc, mem_wdata, exp_wd); end
      end
    end
    if (ec) begin if (exp_read) last_cpu_rd = exp_rd; cpu_req = 1'b0; end
    if (ed) begin if (exp_read) last_dma_rd = exp_rd; dma_req = 1'b0; end
    if (!cpu_req && !ec && $urandom_range(99) < p_cpu)
      set_cpu(1'($urandom_range(1)), AW'($urandom_range(31)), DW'($urandom));
    if (!dma_req && !ed && $urandom_range(99) < p_dma)
      set_dma(1'($urandom_range(1)), AW'($urandom_range(31)), DW'($urandom));
    if (cyc == idle_cyc) begin
      if (cpu_req || dma_req) begin
        if (cpu_req && dma_req) begin
`ifdef MANO_ARB_RR_EN
          win = (last_grant == 1) ? 2 : 1;
`else
          win = (starve == SMAX) ? 2 : 1;
`endif
        end else begin
          win = cpu_req ? 1 : 2;
        end
`ifdef MANO_ARB_RR_EN
        last_grant = win;
`else
        if (win == 2 || !dma_req) starve = 0;
        else if (starve < SMAX)   starve++;
`endif
        if (win == 1) begin exp_we = cpu_we; exp_addr = cpu_addr; exp_wd = cpu_wdata; end
        else          begin exp_we = dma_we; exp_addr = dma_addr; exp_wd = dma_wdata; end
        if (exp_we) begin gmem[exp_addr] = exp_wd; exp_read = 1'b0; end
        else        begin exp_rd = gmem[exp_addr]; exp_read = 1'b1; end
        ack_port = win; ack_cyc = cyc + 2; idle_cyc = cyc + 3;
        grant_log.push_back(win);
      end else begin
        idle_cyc = cyc + 1;
`ifndef MANO_ARB_RR_EN
        starve = 0;
`endif
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1; mem_load = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; mem_load = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    checks++;
    if ({cpu_ack, dma_ack, mem_en, mem_we, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b expected 00000", {cpu_ack, dma_ack, mem_en, mem_we, busy});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++; $display("FAIL reset_mem got addr=%0d wdata=%h expected 0", mem_addr, mem_wdata);
    end
    checks++;
    if (cpu_rdata !== '0 || dma_rdata !== '0) begin
      errors++; $display("FAIL reset_rdata got %h/%h expected 0", cpu_rdata, dma_rdata);
    end
  endtask

  task automatic test_single_read();
    set_cpu(1'b0, 5'd10, '0);
    step();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 5'd10) begin
      errors++; $display("FAIL single_issue got en=%b addr=%0d expected en=1 addr=10", mem_en, mem_addr);
    end
    step();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h0005) begin
      errors++; $display("FAIL single_ack got ack=%b rdata=%h expected ack=1 rdata=0005", cpu_ack, cpu_rdata);
    end
    repeat (2) step();
  endtask

  task automatic test_dma_then_cpu();
    logic seen;
    set_dma(1'b1, 5'd3, 16'hBEEF);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (dma_ack) seen = 1'b1;
      step();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL dma_write_ack got none expected one"); end
    set_cpu(1'b0, 5'd3, '0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (cpu_ack) begin
        seen = 1'b1;
        checks++;
        if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL cpu_read_after_dma got %h expected beef", cpu_rdata); end
      end
      step();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL cpu_read_after_dma_ack got none expected one"); end
  endtask

  task automatic test_priority();
    int exp_seq[10];
    int n;
`ifdef MANO_ARB_RR_EN
    exp_seq = '{2, 1, 2, 1, 2, 1, 2, 1, 2, 1};
`else
    exp_seq = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
`endif
    apply_reset();
    for (int i = 0; i < 31; i++) begin
      if (!cpu_req) set_cpu(1'($urandom_range(1)), AW'($urandom_range(31)), DW'($urandom));
      if (!dma_req) set_dma(1'($urandom_range(1)), AW'($urandom_range(31)), DW'($urandom));
      step();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (3) step();
    n = grant_log.size();
    checks++;
    if (n < 10) begin errors++; $display("FAIL grant_count got %0d expected >=10", n); end
    for (int i = 0; i < 10 && i < n; i++) begin
      checks++;
      if (grant_log[i] !== exp_seq[i]) begin
        errors++; $display("FAIL grant_order[%0d] got %0d expected %0d (1=CPU 2=DMA)", i, grant_log[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_reset_inflight();
    logic seen;
    apply_reset();
    set_cpu(1'b0, 5'd10, '0);
    step();
    rst = 1'b1; mem_load = 1'b1; cpu_req = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL reset_inflight got busy=%b en=%b ack=%b expected 0", busy, mem_en, cpu_ack);
    end
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_no_ack got %b expected 0", cpu_ack); end
    rst = 1'b0; mem_load = 1'b0;
    model_reset();
    repeat (3) step();
    set_cpu(1'b0, 5'd10, '0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (cpu_ack) begin
        seen = 1'b1;
        checks++;
        if (cpu_rdata !== 16'h0005) begin errors++; $display("FAIL rerequest_rdata got %h expected 0005", cpu_rdata); end
      end
      step();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rerequest_ack got none expected one"); end
  endtask

  task automatic test_cpu_only();
    int n;
    apply_reset();
    n = 0;
    for (int i = 0; i < 60 && n < 10; i++) begin
      if (cpu_ack) n++;
      if (!cpu_req && n < 10) set_cpu(1'b0, AW'($urandom_range(31)), '0);
      step();
    end
    checks++;
    if (n != 10) begin errors++; $display("FAIL cpu_only_acks got %0d expected 10", n); end
    repeat (3) step();
  endtask

  task automatic test_random();
    apply_reset();
    p_cpu = 40; p_dma = 40;
    repeat (1500) step();
    p_cpu = 0; p_dma = 0;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (grant_log.size() < 100) begin errors++; $display("FAIL random_grants got %0d expected >=100", grant_log.size()); end
  endtask

  initial begin
    @(negedge clk);
    apply_reset();
    test_reset();
    test_single_read();
    test_dma_then_cpu();
    test_priority();
    test_reset_inflight();
    test_cpu_only();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
